// File: rtl/pipe_hazard_ctrl.sv
//==============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline hazard unit with X-stage forwarding, load-use stall,
//            branch flush and memory-wait freeze. Optional macro HZ_PERF_EN
//            adds saturating performance counters.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_valid,
  input  logic [NUM_SRC*REG_AW-1:0] d_rs,
  input  logic [NUM_SRC-1:0]        d_rs_used,
  input  logic [REG_AW-1:0]         d_rd,
  input  logic                      d_wen,
  input  logic                      d_is_load,
  input  logic                      x_br_taken,
  input  logic                      m_mem_req,
  input  logic                      m_mem_ack,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall_pc,
  output logic                      stall_d,
  output logic                      freeze,
  output logic                      flush_d,
  output logic                      bubble_x
`ifdef HZ_PERF_EN
  ,
  output logic [31:0]               perf_stall_cyc,
  output logic [31:0]               perf_flush_cnt,
  output logic [31:0]               perf_lu_cnt
`endif
);

  logic                      x_valid_q;
  logic [NUM_SRC*REG_AW-1:0] x_rs_q;
  logic [NUM_SRC-1:0]        x_rs_used_q;
  logic [REG_AW-1:0]         x_rd_q;
  logic                      x_wen_q;
  logic                      x_is_load_q;

  logic [FWD_DEPTH-1:0]      sb_valid_q;
  logic [FWD_DEPTH-1:0]      sb_wen_q;
  logic [REG_AW-1:0]         sb_rd_q [FWD_DEPTH];

  logic mem_wait;
  logic br_kill;
  logic load_use;
  logic lu_hit;

  // Scan oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (x_valid_q && x_rs_used_q[i] && sb_valid_q[k] && sb_wen_q[k] &&
            (sb_rd_q[k] != '0) && (sb_rd_q[k] == x_rs_q[i*REG_AW +: REG_AW])) begin
          fwd_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (d_rs_used[i] && (d_rs[i*REG_AW +: REG_AW] == x_rd_q)) begin
        lu_hit = 1'b1;
      end
    end
  end

  assign mem_wait = m_mem_req && !m_mem_ack && sb_valid_q[0];
  assign br_kill  = x_valid_q && x_br_taken;
  assign load_use = x_valid_q && x_is_load_q && x_wen_q && (x_rd_q != '0) &&
                    d_valid && lu_hit;

  always_comb begin
    stall_pc = 1'b0;
    stall_d  = 1'b0;
    freeze   = 1'b0;
    flush_d  = 1'b0;
    bubble_x = 1'b0;
    if (mem_wait) begin
      freeze   = 1'b1;
      stall_pc = 1'b1;
      stall_d  = 1'b1;
    end else if (br_kill) begin
      flush_d  = 1'b1;
      bubble_x = 1'b1;
    end else if (load_use) begin
      stall_pc = 1'b1;
      stall_d  = 1'b1;
      bubble_x = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_valid_q   <= 1'b0;
      x_rs_q      <= '0;
      x_rs_used_q <= '0;
      x_rd_q      <= '0;
      x_wen_q     <= 1'b0;
      x_is_load_q <= 1'b0;
      sb_valid_q  <= '0;
      sb_wen_q    <= '0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        sb_rd_q[k] <= '0;
      end
    end else if (!mem_wait) begin
      for (int k = 1; k < FWD_DEPTH; k++) begin
        sb_valid_q[k] <= sb_valid_q[k-1];
        sb_wen_q[k]   <= sb_wen_q[k-1];
        sb_rd_q[k]    <= sb_rd_q[k-1];
      end
      sb_valid_q[0] <= x_valid_q;
      sb_wen_q[0]   <= x_wen_q;
      sb_rd_q[0]    <= x_rd_q;
      x_valid_q     <= d_valid && !br_kill && !load_use;
      x_rs_q        <= d_rs;
      x_rs_used_q   <= d_rs_used;
      x_rd_q        <= d_rd;
      x_wen_q       <= d_wen;
      x_is_load_q   <= d_is_load;
    end
  end

`ifdef HZ_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_lu_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_lu_q    <= '0;
    end else begin
      if (stall_pc && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
      if (br_kill && !mem_wait && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 32'd1;
      // A load-use bubble only lands when nothing of higher priority pre-empts it.
      if (load_use && !br_kill && !mem_wait && (perf_lu_q != '1)) perf_lu_q <= perf_lu_q + 32'd1;
    end
  end

  assign perf_stall_cyc = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_lu_cnt    = perf_lu_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
//==============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic [9:0]  d_rs;
  logic [1:0]  d_rs_used;
  logic [4:0]  d_rd;
  logic        d_wen;
  logic        d_is_load;
  logic        x_br_taken;
  logic        m_mem_req;
  logic        m_mem_ack;
  logic [3:0]  fwd_sel;
  logic        stall_pc;
  logic        stall_d;
  logic        freeze;
  logic        flush_d;
  logic        bubble_x;
`ifdef HZ_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_lu_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .d_valid    (d_valid),
    .d_rs       (d_rs),
    .d_rs_used  (d_rs_used),
    .d_rd       (d_rd),
    .d_wen      (d_wen),
    .d_is_load  (d_is_load),
    .x_br_taken (x_br_taken),
    .m_mem_req  (m_mem_req),
    .m_mem_ack  (m_mem_ack),
    .fwd_sel    (fwd_sel),
    .stall_pc   (stall_pc),
    .stall_d    (stall_d),
    .freeze     (freeze),
    .flush_d    (flush_d),
    .bubble_x   (bubble_x)
`ifdef HZ_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_lu_cnt    (perf_lu_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd,
                       input logic wen, input logic ld);
    d_valid   = v;
    d_rs      = {rs1, rs0};
    d_rs_used = used;
    d_rd      = rd;
    d_wen     = wen;
    d_is_load = ld;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk({tag, "_ctrl"}, {27'd0, stall_pc, stall_d, freeze, flush_d, bubble_x}, {27'd0, exp});
  endtask

  initial begin
    rst = 1'b0;
    set_d(0, 0, 0, 2'b00, 0, 0, 0);
    x_br_taken = 1'b0;
    m_mem_req  = 1'b0;
    m_mem_ack  = 1'b0;
    #2;
    chk("reset_fwd", {28'd0, fwd_sel}, 32'h0);
    chk_ctrl("reset", 5'b00000);
    #10 rst = 1'b1;
    tick;

    // Forwarding chain: ADD x5, reader in X next, second reader two behind.
    set_d(1, 1, 2, 2'b11, 5, 1, 0);
    tick;
    set_d(1, 5, 0, 2'b11, 6, 1, 0);
    #1 chk("fwd_none", {28'd0, fwd_sel}, 32'h0);
    tick;
    set_d(1, 1, 5, 2'b11, 0, 0, 0);
    #1 chk("fwd_m", {28'd0, fwd_sel}, 32'h1);
    chk_ctrl("fwd_m", 5'b00000);
    tick;
    set_d(1, 0, 0, 2'b00, 7, 1, 0);
    #1 chk("fwd_w", {28'd0, fwd_sel}, 32'h8);
    chk_ctrl("fwd_w", 5'b00000);
    tick;
    set_d(1, 0, 0, 2'b00, 7, 1, 0);
    tick;
    set_d(1, 7, 0, 2'b11, 0, 1, 0);
    tick;
    set_d(1, 0, 7, 2'b11, 0, 0, 0);
    #1 chk("youngest", {28'd0, fwd_sel}, 32'h1);
    tick;
    set_d(0, 0, 0, 2'b00, 0, 0, 0);
    #1 chk("x0_never", {28'd0, fwd_sel}, 32'h8);
    tick;

    // Load-use: one bubble, then the pipe flows.
    set_d(1, 0, 0, 2'b00, 3, 1, 1);
    tick;
    set_d(1, 3, 0, 2'b01, 8, 1, 0);
    #1 chk_ctrl("lu_stall", 5'b11001);
    tick;
    #1 chk_ctrl("lu_after", 5'b00000);
    tick;
    set_d(0, 0, 0, 2'b00, 0, 0, 0);
    #1 chk_ctrl("lu_flow", 5'b00000);

    // Branch overriding a simultaneous load-use; the killed x9 writer never forwards.
    set_d(1, 0, 0, 2'b00, 4, 1, 1);
    tick;
    set_d(1, 4, 0, 2'b01, 9, 1, 0);
    x_br_taken = 1'b1;
    #1 chk_ctrl("br_kill", 5'b00011);
    tick;
    x_br_taken = 1'b0;
    set_d(1, 9, 0, 2'b01, 0, 0, 0);
    #1 chk_ctrl("br_after", 5'b00000);
    tick;
    set_d(0, 0, 0, 2'b00, 0, 0, 0);
    #1 chk("br_no_sb", {28'd0, fwd_sel}, 32'h0);

    // Memory wait holding a pending branch for three cycles.
    set_d(1, 0, 0, 2'b00, 10, 1, 0);
    tick;
    set_d(1, 0, 0, 2'b00, 0, 0, 0);
    tick;
    set_d(1, 0, 0, 2'b00, 11, 1, 0);
    m_mem_req  = 1'b1;
    m_mem_ack  = 1'b0;
    x_br_taken = 1'b1;
    #1 chk_ctrl("mw_c1", 5'b11100);
    tick;
    #1 chk_ctrl("mw_c2", 5'b11100);
    tick;
    #1 chk_ctrl("mw_c3", 5'b11100);
    tick;
    m_mem_ack = 1'b1;
    #1 chk_ctrl("mw_ack", 5'b00011);
    tick;
    m_mem_req = 1'b0;
    m_mem_ack = 1'b0;
    #1 chk_ctrl("mw_once", 5'b00000);
    x_br_taken = 1'b0;
    set_d(0, 0, 0, 2'b00, 0, 0, 0);
    tick;

    // Asynchronous reset in the middle of a load-use stall.
    set_d(1, 0, 0, 2'b00, 3, 1, 1);
    tick;
    set_d(1, 3, 0, 2'b01, 8, 1, 0);
    #1 chk_ctrl("rst_pre", 5'b11001);
    #1 rst = 1'b0;
    #1 chk_ctrl("rst_mid", 5'b00000);
    chk("rst_fwd", {28'd0, fwd_sel}, 32'h0);
`ifdef HZ_PERF_EN
    chk("rst_perf_stall", perf_stall_cyc, 32'h0);
    chk("rst_perf_flush", perf_flush_cnt, 32'h0);
    chk("rst_perf_lu", perf_lu_cnt, 32'h0);
`endif
    set_d(0, 0, 0, 2'b00, 0, 0, 0);
    rst = 1'b1;
    tick;
    #1 chk_ctrl("rst_idle", 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
